// File: rtl/ttm4_exec_unit_pkg.sv
// Shared widths, opcode encodings and decode payload for the TTM4 execution stage.
package ttm4_exec_unit_pkg;

  localparam int unsigned TTM4_DATA_W = 4;
  localparam int unsigned TTM4_ADDR_W = 4;
  localparam int unsigned INSTR_W     = 8;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned IMM_W       = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOVI_A = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOVI_B = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_IN   = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_A    = 2'd1,
    DST_B    = 2'd2,
    DST_OUT  = 2'd3
  } dst_e;

  typedef struct packed {
    src_e src;
    dst_e dst;
    logic is_jmp;
    logic is_jnc;
  } decode_t;

endpackage

// File: rtl/ttm4_exec_unit_decoder.sv
// Opcode decoder: maps the upper ROM nibble to source, destination and branch kind.
module ttm4_exec_unit_decoder
  import ttm4_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output decode_t         dec
);

  // Table lookup; unlisted opcodes decode as NOP (no source, no store, no jump)
  always_comb begin
    dec.src    = SRC_NONE;
    dec.dst    = DST_NONE;
    dec.is_jmp = 1'b0;
    dec.is_jnc = 1'b0;
    case (opcode)
      OP_ADD_A:  begin dec.src = SRC_A;  dec.dst = DST_A;   end
      OP_MOV_AB: begin dec.src = SRC_B;  dec.dst = DST_A;   end
      OP_IN_A:   begin dec.src = SRC_IN; dec.dst = DST_A;   end
      OP_MOVI_A: begin                   dec.dst = DST_A;   end
      OP_MOV_BA: begin dec.src = SRC_A;  dec.dst = DST_B;   end
      OP_ADD_B:  begin dec.src = SRC_B;  dec.dst = DST_B;   end
      OP_IN_B:   begin dec.src = SRC_IN; dec.dst = DST_B;   end
      OP_MOVI_B: begin                   dec.dst = DST_B;   end
      OP_OUT_B:  begin dec.src = SRC_B;  dec.dst = DST_OUT; end
      OP_OUT_IM: begin                   dec.dst = DST_OUT; end
      OP_JNC:    dec.is_jnc = 1'b1;
      OP_JMP:    dec.is_jmp = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/ttm4_exec_unit.sv
// TTM4 execution stage: decode, operand select, 4-bit add, carry flag and program counter.
module ttm4_exec_unit
  import ttm4_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = TTM4_DATA_W,
  parameter int unsigned ADDR_W = TTM4_ADDR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic [DATA_W-1:0]  BUSDATA,
  output logic [ADDR_W-1:0]  PC,
  output logic               CARRY,
  output logic [DATA_W-1:0]  STOREDATA,
  output logic               nA_OUT,
  output logic               nB_OUT,
  output logic               nIN_OUT,
  output logic               nA_ST,
  output logic               nB_ST,
  output logic               nOUT_ST
);

  decode_t           dec;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic              store_en;
  logic              take_branch;

  ttm4_exec_unit_decoder u_decoder (
    .opcode (INSTR[INSTR_W-1:IMM_W]),
    .dec    (dec)
  );

  assign imm = DATA_W'(INSTR[IMM_W-1:0]);

  // Source enables; operand is forced to zero when nothing drives the bus
  always_comb begin
    nA_OUT  = 1'b1;
    nB_OUT  = 1'b1;
    nIN_OUT = 1'b1;
    operand = '0;
    case (dec.src)
      SRC_A:   begin nA_OUT  = 1'b0; operand = BUSDATA; end
      SRC_B:   begin nB_OUT  = 1'b0; operand = BUSDATA; end
      SRC_IN:  begin nIN_OUT = 1'b0; operand = BUSDATA; end
      default: ;
    endcase
  end

  // Adder (74HC283 equivalent); carry-out goes to the flag
  assign sum       = (DATA_W+1)'(operand) + (DATA_W+1)'(imm);
  assign STOREDATA = sum[DATA_W-1:0];

  // Store strobes only fire on an executing, non-reset edge
  assign store_en = CE & ~RST;
  assign nA_ST    = ~(store_en && (dec.dst == DST_A));
  assign nB_ST    = ~(store_en && (dec.dst == DST_B));
  assign nOUT_ST  = ~(store_en && (dec.dst == DST_OUT));

  // JNC looks at the flag left by the previous executed instruction
  assign take_branch = dec.is_jmp | (dec.is_jnc & ~CARRY);

  // Carry flag and program counter (161-style sync load / count)
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC    <= '0;
      CARRY <= 1'b0;
    end else if (CE) begin
      CARRY <= sum[DATA_W];
      if (take_branch) PC <= ADDR_W'(imm);
      else             PC <= PC + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ttm4_exec_unit.sv
// Self-checking bench for ttm4_exec_unit with a queue-based scoreboard for PC/CARRY.
module tb_ttm4_exec_unit;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [7:0] instr;
  logic [3:0] busdata;
  logic [3:0] pc;
  logic       carry;
  logic [3:0] storedata;
  logic       na_out, nb_out, nin_out, na_st, nb_st, nout_st;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_pc;
  logic       m_carry;
  logic [4:0] sb_q[$];

  ttm4_exec_unit dut (
    .CLK       (clk),
    .RST       (rst),
    .CE        (ce),
    .INSTR     (instr),
    .BUSDATA   (busdata),
    .PC        (pc),
    .CARRY     (carry),
    .STOREDATA (storedata),
    .nA_OUT    (na_out),
    .nB_OUT    (nb_out),
    .nIN_OUT   (nin_out),
    .nA_ST     (na_st),
    .nB_ST     (nb_st),
    .nOUT_ST   (nout_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference opcode table: src 0=none 1=A 2=B 3=IN; dst 0=none 1=A 2=B 3=OUT
  task automatic ref_decode(input logic [3:0] op, output int src, output int dst,
                            output bit jmp, output bit jnc);
    src = 0; dst = 0; jmp = 0; jnc = 0;
    case (op)
      4'h0: begin src = 1; dst = 1; end
      4'h5: begin src = 2; dst = 2; end
      4'h3: dst = 1;
      4'h7: dst = 2;
      4'h1: begin src = 2; dst = 1; end
      4'h4: begin src = 1; dst = 2; end
      4'h2: begin src = 3; dst = 1; end
      4'h6: begin src = 3; dst = 2; end
      4'h9: begin src = 2; dst = 3; end
      4'hB: dst = 3;
      4'hF: jmp = 1;
      4'hE: jnc = 1;
      default: ;
    endcase
  endtask

  // Drive one instruction, check combinational outputs, then check PC/CARRY after the edge
  task automatic step(input logic r, input logic c, input logic [7:0] ins, input logic [3:0] bus);
    int src, dst;
    bit jmp, jnc;
    logic [4:0] s;
    logic [4:0] got;
    logic       en;
    rst = r; ce = c; instr = ins; busdata = bus;
    #1;
    ref_decode(ins[7:4], src, dst, jmp, jnc);
    s  = {1'b0, (src != 0) ? bus : 4'h0} + {1'b0, ins[3:0]};
    en = c && !r;
    check("nA_OUT",    32'(na_out),    32'(src != 1));
    check("nB_OUT",    32'(nb_out),    32'(src != 2));
    check("nIN_OUT",   32'(nin_out),   32'(src != 3));
    check("nA_ST",     32'(na_st),     32'(!(en && dst == 1)));
    check("nB_ST",     32'(nb_st),     32'(!(en && dst == 2)));
    check("nOUT_ST",   32'(nout_st),   32'(!(en && dst == 3)));
    check("STOREDATA", 32'(storedata), 32'(s[3:0]));
    if (r) begin
      m_pc = 4'h0; m_carry = 1'b0;
    end else if (c) begin
      if (jmp || (jnc && !m_carry)) m_pc = ins[3:0];
      else                          m_pc = m_pc + 4'h1;
      m_carry = s[4];
    end
    sb_q.push_back({m_carry, m_pc});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(0), 32'(1));
    end else begin
      got = sb_q.pop_front();
      check("PC",    32'(pc),    32'(got[3:0]));
      check("CARRY", 32'(carry), 32'(got[4]));
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; instr = 8'hF5; busdata = 4'h0;
    m_pc = 4'h0; m_carry = 1'b0;
    @(negedge clk);

    // Reset beats a JMP
    step(1'b1, 1'b1, 8'hF5, 4'h0);
    step(1'b1, 1'b1, 8'hF5, 4'h0);

    // MOV A,IM
    step(1'b0, 1'b1, 8'h3A, 4'h5);
    // ADD A,IM with carry out, then JNC with carry set falls through
    step(1'b0, 1'b1, 8'h0F, 4'h3);
    step(1'b0, 1'b1, 8'hE7, 4'h0);
    // JNC taken, JMP, jump to 15, NOP wraps PC to 0
    step(1'b0, 1'b1, 8'hE7, 4'h0);
    step(1'b0, 1'b1, 8'hF5, 4'h0);
    step(1'b0, 1'b1, 8'hFF, 4'h0);
    step(1'b0, 1'b1, 8'h80, 4'h0);
    // Hold while CE low
    step(1'b0, 1'b0, 8'h0F, 4'h1);
    // OUT B, OUT IM
    step(1'b0, 1'b1, 8'h90, 4'hC);
    step(1'b0, 1'b1, 8'hB6, 4'h9);
    // Source/dest variety
    step(1'b0, 1'b1, 8'h12, 4'h7);
    step(1'b0, 1'b1, 8'h44, 4'hD);
    step(1'b0, 1'b1, 8'h23, 4'hE);
    step(1'b0, 1'b1, 8'h61, 4'hF);
    step(1'b0, 1'b1, 8'h5E, 4'h2);
    step(1'b0, 1'b1, 8'h79, 4'h8);

    // Random instructions with occasional CE gaps and resets
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
